// File: rtl/bcd_calc_engine.sv
// Sign-magnitude BCD keypad calculator: operand entry FSM with a digit-serial add/subtract core.
// Define MEM_EN to build the MS/MR/MC memory register; without it mem_valid is tied low.
module bcd_calc_engine #(
  parameter int unsigned NDIGITS = 3
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 dig_in,
  input  logic [3:0]           dig_code,
  input  logic                 op_in,
  input  logic [1:0]           op_code,
  input  logic                 sub_in,
  input  logic                 ex_in,
  input  logic                 reset_in,
  input  logic                 bksp_in,
  input  logic                 MS_in,
  input  logic                 MR_in,
  input  logic                 MC_in,
  output logic [4*NDIGITS-1:0] disp_bcd,
  output logic [3:0]           disp_neg,
  output logic [2:0]           LED,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic                 mem_valid
);
  localparam int unsigned W    = 4 * NDIGITS;
  localparam int unsigned CntW = $clog2(NDIGITS + 1);
  localparam int unsigned IdxW = $clog2(NDIGITS);
  localparam logic [CntW-1:0] CntMax  = CntW'(NDIGITS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NDIGITS - 1);

  typedef enum logic [2:0] {StEnterA, StEnterB, StExec, StFix, StShowR} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, r_q, r_d;
  logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d, r_neg_q, r_neg_d;
  logic [CntW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [1:0]      op_q, op_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            cy_q, cy_d, ovf_q, ovf_d;
  logic [2:0]      led_q, led_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [W-1:0]    disp_mag, r_ins;
  logic            disp_sgn, same_sign, fix_mode, dcy;
  logic [3:0]      da, db, dr;
  logic [4:0]      dsum;

`ifdef MEM_EN
  logic [W-1:0] mem_q, mem_d;
  logic         mem_neg_q, mem_neg_d, mem_valid_q, mem_valid_d;
`endif

  function automatic logic [CntW-1:0] sig_digits(input logic [W-1:0] v);
    sig_digits = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0) sig_digits = CntW'(i + 1);
    end
  endfunction

  function automatic logic [3:0] digit_at(input logic [W-1:0] v, input logic [IdxW-1:0] i);
    digit_at = 4'd0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (IdxW'(k) == i) digit_at = v[4*k +: 4];
    end
  endfunction

  // EXEC/FIX keep showing the operand that was on screen when execute was pressed (B).
  always_comb begin
    unique case (state_q)
      StEnterA: begin disp_mag = a_q; disp_sgn = a_neg_q; end
      StShowR:  begin disp_mag = r_q; disp_sgn = r_neg_q; end
      default:  begin disp_mag = b_q; disp_sgn = b_neg_q; end
    endcase
  end

  // One BCD digit per cycle; FIX reuses the subtractor as 0 - R.
  always_comb begin
    same_sign = (a_neg_q == (b_neg_q ^ (op_q == 2'b01)));
    fix_mode  = (state_q == StFix);
    da        = fix_mode ? 4'd0 : digit_at(a_q, idx_q);
    db        = fix_mode ? digit_at(r_q, idx_q) : digit_at(b_q, idx_q);
    if (same_sign && !fix_mode) begin
      dsum = {1'b0, da} + {1'b0, db} + {4'd0, cy_q};
      dcy  = (dsum > 5'd9);
      dr   = dcy ? 4'(dsum - 5'd10) : dsum[3:0];
    end else begin
      dsum = {1'b0, da} - {1'b0, db} - {4'd0, cy_q};
      dcy  = dsum[4];
      dr   = dcy ? 4'(dsum + 5'd10) : dsum[3:0];
    end
    r_ins = r_q;
    for (int k = 0; k < NDIGITS; k++) begin
      if (IdxW'(k) == idx_q) r_ins[4*k +: 4] = dr;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d = a_q; a_neg_d = a_neg_q; a_cnt_d = a_cnt_q;
    b_d = b_q; b_neg_d = b_neg_q; b_cnt_d = b_cnt_q;
    r_d = r_q; r_neg_d = r_neg_q;
    op_d = op_q; idx_d = idx_q; cy_d = cy_q; ovf_d = ovf_q;
`ifdef MEM_EN
    mem_d = mem_q; mem_neg_d = mem_neg_q; mem_valid_d = mem_valid_q;
`endif
    if (reset_in) begin
      state_d = StEnterA;
      a_d = '0; a_neg_d = 1'b0; a_cnt_d = '0;
      b_d = '0; b_neg_d = 1'b0; b_cnt_d = '0;
      r_d = '0; r_neg_d = 1'b0;
      op_d = 2'b00; idx_d = '0; cy_d = 1'b0; ovf_d = 1'b0;
    end else if (state_q == StExec || state_q == StFix) begin
      r_d   = r_ins;
      cy_d  = dcy;
      idx_d = idx_q + IdxW'(1);
      if (idx_q == IdxLast) begin
        idx_d = '0;
        cy_d  = 1'b0;
        if (state_q == StFix) begin
          r_neg_d = ~a_neg_q && (r_ins != '0);
          state_d = StShowR;
        end else if (op_q[1]) begin
          r_d = '0; r_neg_d = 1'b0; ovf_d = 1'b1; state_d = StShowR;
        end else if (!same_sign && dcy) begin
          state_d = StFix;
        end else begin
          ovf_d   = same_sign && dcy;
          r_neg_d = a_neg_q && (r_ins != '0);
          state_d = StShowR;
        end
      end
    end else if (ex_in) begin
      if (state_q == StEnterB) begin
        state_d = StExec; idx_d = '0; cy_d = 1'b0; ovf_d = 1'b0;
      end
    end else if (op_in || sub_in) begin
      if (!op_in && state_q == StEnterA && a_cnt_q == '0) begin
        a_neg_d = ~a_neg_q;
      end else if (!op_in && state_q == StEnterB && b_cnt_q == '0) begin
        b_neg_d = ~b_neg_q;
      end else begin
        op_d = op_in ? op_code : 2'b01;
        if (state_q != StEnterB) begin
          b_d = '0; b_neg_d = 1'b0; b_cnt_d = '0;
          state_d = StEnterB;
        end
        if (state_q == StShowR) begin
          a_d = r_q; a_neg_d = r_neg_q; a_cnt_d = sig_digits(r_q); ovf_d = 1'b0;
        end
      end
    end else if (dig_in) begin
      if (dig_code <= 4'd9) begin
        if (state_q == StShowR) begin
          a_d = W'(dig_code); a_neg_d = 1'b0; a_cnt_d = CntW'(dig_code != 4'd0);
          b_d = '0; b_neg_d = 1'b0; b_cnt_d = '0;
          r_d = '0; r_neg_d = 1'b0; ovf_d = 1'b0;
          state_d = StEnterA;
        end else if (state_q == StEnterA && a_cnt_q != CntMax &&
                     !(a_cnt_q == '0 && dig_code == 4'd0)) begin
          a_d = {a_q[W-5:0], dig_code}; a_cnt_d = a_cnt_q + CntW'(1);
        end else if (state_q == StEnterB && b_cnt_q != CntMax &&
                     !(b_cnt_q == '0 && dig_code == 4'd0)) begin
          b_d = {b_q[W-5:0], dig_code}; b_cnt_d = b_cnt_q + CntW'(1);
        end
      end
    end else if (bksp_in) begin
      if (state_q == StEnterA) begin
        if (a_cnt_q == '0) a_neg_d = 1'b0;
        else begin a_d = a_q >> 4; a_cnt_d = a_cnt_q - CntW'(1); end
      end else if (state_q == StEnterB) begin
        if (b_cnt_q == '0) b_neg_d = 1'b0;
        else begin b_d = b_q >> 4; b_cnt_d = b_cnt_q - CntW'(1); end
      end
`ifdef MEM_EN
    end else if (MS_in) begin
      mem_d = disp_mag; mem_neg_d = disp_sgn; mem_valid_d = 1'b1;
    end else if (MR_in) begin
      if (mem_valid_q) begin
        if (state_q == StEnterB) begin
          b_d = mem_q; b_neg_d = mem_neg_q; b_cnt_d = sig_digits(mem_q);
        end else begin
          a_d = mem_q; a_neg_d = mem_neg_q; a_cnt_d = sig_digits(mem_q);
          ovf_d = 1'b0; state_d = StEnterA;
        end
      end
    end else if (MC_in) begin
      mem_d = '0; mem_neg_d = 1'b0; mem_valid_d = 1'b0;
`endif
    end

    unique case (state_d)
      StEnterA: led_d = 3'b001;
      StEnterB: led_d = 3'b010;
      StShowR:  led_d = 3'b011;
      default:  led_d = 3'b100;
    endcase
    busy_d = (state_d == StExec) || (state_d == StFix);
    done_d = (state_d == StShowR) && (state_q != StShowR);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StEnterA;
      a_q <= '0; a_neg_q <= 1'b0; a_cnt_q <= '0;
      b_q <= '0; b_neg_q <= 1'b0; b_cnt_q <= '0;
      r_q <= '0; r_neg_q <= 1'b0;
      op_q <= 2'b00; idx_q <= '0; cy_q <= 1'b0; ovf_q <= 1'b0;
      led_q <= 3'b001; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d; a_neg_q <= a_neg_d; a_cnt_q <= a_cnt_d;
      b_q <= b_d; b_neg_q <= b_neg_d; b_cnt_q <= b_cnt_d;
      r_q <= r_d; r_neg_q <= r_neg_d;
      op_q <= op_d; idx_q <= idx_d; cy_q <= cy_d; ovf_q <= ovf_d;
      led_q <= led_d; busy_q <= busy_d; done_q <= done_d;
    end
  end

`ifdef MEM_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_q <= '0; mem_neg_q <= 1'b0; mem_valid_q <= 1'b0;
    end else begin
      mem_q <= mem_d; mem_neg_q <= mem_neg_d; mem_valid_q <= mem_valid_d;
    end
  end
  assign mem_valid = mem_valid_q;
`else
  assign mem_valid = 1'b0;
`endif

  assign disp_bcd = disp_mag;
  assign disp_neg = disp_sgn ? 4'hA : 4'hF;
  assign LED      = led_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
endmodule
